// File: rtl/bytewrite_ram_req_frontend.sv
// Request/response front-end for one port of a byte-write, write-first RAM with 1-cycle read latency.
// Requests pass straight through to the RAM; RAM output is captured into a credit-protected in-order FIFO.
module bytewrite_ram_req_frontend #(
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NUM_COL-1:0]    req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_en,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic                  inflight_q, inflight_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];

    logic fire;
    logic push;
    logic pop;
    logic credit_ok;

    // Credit counts queued plus in-flight words; a same-cycle pop is deliberately not credited.
    assign credit_ok = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(RSP_DEPTH);
    assign req_ready = !rst && credit_ok;
    assign fire      = req_valid && req_ready;

    assign ram_en   = fire;
    assign ram_we   = fire ? req_we : '0;
    assign ram_addr = req_addr;
    assign ram_din  = req_wdata;

    assign rsp_valid = (count_q != '0);
    assign rsp_rdata = mem_q[rd_ptr_q];
    assign push      = inflight_q;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        inflight_d = fire;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = ram_dout;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only observed through count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && count_q == CNT_W'(RSP_DEPTH)));

    a_req_stable : assert property (@(posedge clk) disable iff (rst)
        (req_valid && !req_ready) |=> (req_valid && $stable(req_we)
                                       && $stable(req_addr) && $stable(req_wdata)));

endmodule

// File: tb/tb_bytewrite_ram_req_frontend.sv
// Scoreboard bench for bytewrite_ram_req_frontend driving a behavioural write-first byte-write RAM.
module tb_bytewrite_ram_req_frontend;

    localparam int unsigned NUM_COL    = 4;
    localparam int unsigned COL_WIDTH  = 8;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH;
    localparam int unsigned RSP_DEPTH  = 4;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [NUM_COL-1:0]    req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  ram_en;
    logic [NUM_COL-1:0]    ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    always #5 clk = ~clk;

    bytewrite_ram_req_frontend #(
        .NUM_COL   (NUM_COL),
        .COL_WIDTH (COL_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Behavioural RAM port: write-first, byte-write, one-cycle read latency.
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] ram_w;
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            ram_w = ram[ram_addr];
            for (int c = 0; c < int'(NUM_COL); c++)
                if (ram_we[c]) ram_w[c*COL_WIDTH +: COL_WIDTH] = ram_din[c*COL_WIDTH +: COL_WIDTH];
            ram[ram_addr] <= ram_w;
            ram_dout      <= ram_w;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard state
    logic [DATA_WIDTH-1:0] model [DEPTH];
    logic [DATA_WIDTH-1:0] exp_q [$];
    logic [DATA_WIDTH-1:0] got_log [$];
    int                    fire_log [$];
    int                    pop_log [$];
    int                    cyc = 0;
    int                    first_vld = -1;
    logic [DATA_WIDTH-1:0] mw;

    initial for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    // Monitor: negedge sees the same values the DUT samples at the next posedge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && first_vld < 0) first_vld = cyc;
            if (rsp_valid && rsp_ready) begin
                pop_log.push_back(cyc);
                got_log.push_back(rsp_rdata);
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
                else                   chk("rsp_data", rsp_rdata, exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                fire_log.push_back(cyc);
                mw = model[req_addr];
                for (int c = 0; c < int'(NUM_COL); c++)
                    if (req_we[c]) mw[c*COL_WIDTH +: COL_WIDTH] = req_wdata[c*COL_WIDTH +: COL_WIDTH];
                model[req_addr] = mw;
                exp_q.push_back(mw);
            end
        end
    end

    task automatic clear_logs();
        got_log.delete();
        fire_log.delete();
        pop_log.delete();
        first_vld = -1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
        logic done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("send_accept", 32'(done), 32'd1);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || rsp_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // 1: reset with a request offered
        repeat (2) begin
            @(negedge clk);
            chk("t1_ram_en", 32'(ram_en), 32'd0);
            chk("t1_ready", 32'(req_ready), 32'd0);
            chk("t1_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;

        // 2: write then read, with latency
        clear_logs();
        rsp_ready = 1'b1;
        send(4'b1111, 10'h005, 32'hDEADBEEF);
        send(4'b0000, 10'h005, 32'h0);
        idle();
        drain();
        chk("t2_count", 32'(got_log.size()), 32'd2);
        chk("t2_rsp0", got_log[0], 32'hDEADBEEF);
        chk("t2_rsp1", got_log[1], 32'hDEADBEEF);
        chk("t2_latency", 32'(first_vld - fire_log[0]), 32'd2);

        // 3: partial byte write
        clear_logs();
        send(4'b1111, 10'h010, 32'h11223344);
        send(4'b0101, 10'h010, 32'hAABBCCDD);
        send(4'b0000, 10'h010, 32'h0);
        idle();
        drain();
        chk("t3_preload", got_log[0], 32'h11223344);
        chk("t3_bytewr", got_log[1], 32'h11BB33DD);
        chk("t3_read", got_log[2], 32'h11BB33DD);

        // 4: back-to-back throughput
        clear_logs();
        for (int i = 0; i < 16; i++) send(4'b0000, 10'(i), 32'h0);
        idle();
        drain();
        chk("t4_accepts", 32'(fire_log.size()), 32'd16);
        chk("t4_accept_span", 32'(fire_log[15] - fire_log[0]), 32'd15);
        chk("t4_rsps", 32'(pop_log.size()), 32'd16);
        chk("t4_rsp_span", 32'(pop_log[15] - pop_log[0]), 32'd15);

        // 5: backpressure
        clear_logs();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'b1111, 10'(32'h100 + i), 32'h5000_0000 + 32'(i));
        req_valid = 1'b1;
        req_we    = 4'b1111;
        req_addr  = 10'h104;
        req_wdata = 32'h5000_0004;
        repeat (5) begin @(posedge clk); #1; end
        chk("t5_accepted", 32'(fire_log.size()), 32'd4);
        @(negedge clk);
        chk("t5_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 4; i < 10; i++) send(4'b1111, 10'(32'h100 + i), 32'h5000_0000 + 32'(i));
        idle();
        drain();
        chk("t5_count", 32'(got_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) chk("t5_order", got_log[i], 32'h5000_0000 + 32'(i));

        // 6: reset with two queued and one in flight
        clear_logs();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'b1111, 10'(32'h200 + i), 32'h6000_0000 + 32'(i));
        chk("t6_pre_valid", 32'(rsp_valid), 32'd1);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_flushed", 32'(rsp_valid), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("t6_no_stale", 32'(got_log.size()), 32'd0);
        send(4'b0000, 10'h005, 32'h0);
        idle();
        drain();
        chk("t6_read", got_log[0], 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
